// File: rtl/pixel_window_pkg.sv
// Shared types for the 3x3 pixel neighbourhood generator.
package pixel_window_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } win_state_e;

  // One window column: rows m (oldest line), 0 (previous line), p (current line).
  typedef struct packed {
    pixel_t m;
    pixel_t z;
    pixel_t p;
  } column_t;

  // The eight neighbours of the window centre; z stands for offset 0.
  typedef struct packed {
    pixel_t pp;
    pixel_t p0;
    pixel_t pm;
    pixel_t zp;
    pixel_t zm;
    pixel_t mp;
    pixel_t m0;
    pixel_t mm;
  } window_t;

endpackage

// File: rtl/pixel_window_3x3_line_buffer.sv
// Single-port line store: the read returns the old word at addr while the
// same address is overwritten at the clock edge (read-before-write).
module line_buffer
  import pixel_window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  pixel_t        din,
  output pixel_t        dout
);

  pixel_t mem [DEPTH];

  // Asynchronous read so the old word is available in the same cycle as the write.
  assign dout = mem[addr];

  // Write the new line's pixel over the one just read.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two chained line buffers, a
// two-column shift array and registered window outputs with edge/eof flags.
module pixel_window_3x3
  import pixel_window_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] in_pixel,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] pixel_pp,
  output logic [7:0] pixel_p0,
  output logic [7:0] pixel_pm,
  output logic [7:0] pixel_0p,
  output logic [7:0] pixel_0m,
  output logic [7:0] pixel_mp,
  output logic [7:0] pixel_m0,
  output logic [7:0] pixel_mm,
  output logic       out_valid,
  output logic       on_edge,
  output logic       out_eof
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);

  win_state_e      state_reg, state_next;
  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [FW-1:0]   flush_cnt_reg;
  column_t         col_p_reg, col_0_reg;
  window_t         win_reg, win_next;
  logic            valid_reg, valid_next;
  logic            edge_reg, edge_next;
  logic            eof_reg, eof_next;
  logic            ready_reg;

  logic            xfer;
  logic            lb_we;
  logic [XW-1:0]   lb_addr;
  pixel_t          lb_din [2];
  pixel_t          lb_q   [2];
  logic            last_pixel;
  logic            fill_done;
  logic            flush_done;

  assign xfer       = in_valid && ready_reg;
  // A pixel enters the line store unless it is dropped while hunting for sof.
  assign lb_we      = xfer && ((state_reg != IDLE) || in_sof);
  // An sof pixel is always column 0, whatever the counters say.
  assign lb_addr    = in_sof ? '0 : x_reg;
  assign last_pixel = (x_reg == XW'(IMG_WIDTH - 1)) && (y_reg == YW'(IMG_HEIGHT - 1));
  assign fill_done  = (x_reg == '0) && (y_reg == YW'(1));
  assign flush_done = (flush_cnt_reg == FW'(IMG_WIDTH));

  // lb0 takes the incoming pixel, lb1 takes what lb0 held (one line older).
  assign lb_din[0] = in_pixel;
  assign lb_din[1] = lb_q[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lb
      line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (XW)
      ) u_lb (
        .clock (clock),
        .addr  (lb_addr),
        .we    (lb_we),
        .din   (lb_din[gi]),
        .dout  (lb_q[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; sof on any accepted pixel restarts the fill.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (xfer && in_sof) state_next = FILL;
      end
      FILL: begin
        if (xfer) begin
          if (in_sof)         state_next = FILL;
          else if (fill_done) state_next = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (in_sof)          state_next = FILL;
          else if (last_pixel) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next window outputs: real windows in RUN, zeroed border windows in FLUSH.
  always_comb begin
    win_next   = '0;
    valid_next = 1'b0;
    edge_next  = 1'b0;
    eof_next   = 1'b0;
    if (state_reg == RUN && xfer && !in_sof) begin
      valid_next  = 1'b1;
      // Centre is (x-1, y-1); x of 0 or 1 puts it in the last/first column.
      edge_next   = (x_reg == '0) || (x_reg == XW'(1)) || (y_reg == YW'(1));
      win_next.pp = in_pixel;
      win_next.p0 = lb_q[0];
      win_next.pm = lb_q[1];
      win_next.zp = col_p_reg.p;
      win_next.zm = col_p_reg.m;
      win_next.mp = col_0_reg.p;
      win_next.m0 = col_0_reg.z;
      win_next.mm = col_0_reg.m;
    end else if (state_reg == FLUSH) begin
      valid_next = 1'b1;
      edge_next  = 1'b1;
      eof_next   = flush_done;
    end
  end

  // Registered outputs; in_ready follows the state being entered.
  always_ff @(posedge clock) begin
    if (rst) begin
      win_reg   <= '0;
      valid_reg <= 1'b0;
      edge_reg  <= 1'b0;
      eof_reg   <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      win_reg   <= win_next;
      valid_reg <= valid_next;
      edge_reg  <= edge_next;
      eof_reg   <= eof_next;
      ready_reg <= (state_next != FLUSH);
    end
  end

  // Position counters track the next input position; sof pixel is (0,0).
  always_ff @(posedge clock) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (lb_we) begin
      if (in_sof) begin
        x_reg <= XW'(1);
        y_reg <= '0;
      end else if (x_reg == XW'(IMG_WIDTH - 1)) begin
        x_reg <= '0;
        y_reg <= y_reg + YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

  // Counts emitted flush windows; parked at zero outside FLUSH.
  always_ff @(posedge clock) begin
    if (rst) begin
      flush_cnt_reg <= '0;
    end else if (state_reg == FLUSH) begin
      flush_cnt_reg <= flush_cnt_reg + FW'(1);
    end else begin
      flush_cnt_reg <= '0;
    end
  end

  // Window shift: old column p becomes column 0, the new column enters at p.
  always_ff @(posedge clock) begin
    if (rst) begin
      col_p_reg <= '0;
      col_0_reg <= '0;
    end else if (lb_we) begin
      col_0_reg <= col_p_reg;
      col_p_reg <= '{m: lb_q[1], z: lb_q[0], p: in_pixel};
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = valid_reg;
  assign on_edge   = edge_reg;
  assign out_eof   = eof_reg;
  assign pixel_pp  = win_reg.pp;
  assign pixel_p0  = win_reg.p0;
  assign pixel_pm  = win_reg.pm;
  assign pixel_0p  = win_reg.zp;
  assign pixel_0m  = win_reg.zm;
  assign pixel_mp  = win_reg.mp;
  assign pixel_m0  = win_reg.m0;
  assign pixel_mm  = win_reg.mm;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Directed bench for pixel_window_3x3 on a 4x3 image.
module tb_pixel_window_3x3;
  import pixel_window_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_pixel = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready;
  logic [7:0] pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm;
  logic       out_valid, on_edge, out_eof;

  typedef struct {
    logic    e;
    logic    f;
    window_t w;
    int      cyc;
  } cap_t;

  cap_t win_q[$];
  int   xfer_cyc[$];
  int   cyc = 0;
  int   ready_low = 0;
  int   checks = 0;
  int   errors = 0;

  pixel_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .pixel_pp  (pixel_pp),
    .pixel_p0  (pixel_p0),
    .pixel_pm  (pixel_pm),
    .pixel_0p  (pixel_0p),
    .pixel_0m  (pixel_0m),
    .pixel_mp  (pixel_mp),
    .pixel_m0  (pixel_m0),
    .pixel_mm  (pixel_mm),
    .out_valid (out_valid),
    .on_edge   (on_edge),
    .out_eof   (out_eof)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every window and count in_ready-low cycles, sampled mid-cycle.
  always @(negedge clock) begin
    cap_t c;
    if (out_valid === 1'b1) begin
      c.e   = on_edge;
      c.f   = out_eof;
      c.w   = '{pp: pixel_pp, p0: pixel_p0, pm: pixel_pm, zp: pixel_0p,
                zm: pixel_0m, mp: pixel_mp, m0: pixel_m0, mm: pixel_mm};
      c.cyc = cyc;
      win_q.push_back(c);
      $display("window #%0d cyc=%0d edge=%b eof=%b pp=%0d p0=%0d pm=%0d 0p=%0d 0m=%0d mp=%0d m0=%0d mm=%0d",
               win_q.size() - 1, cyc, on_edge, out_eof, pixel_pp, pixel_p0, pixel_pm,
               pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm);
    end
    if (!rst && in_ready === 1'b0) ready_low++;
  end

  // Hand-computed interior windows of the 4x3 frame (pixel = base + raster index):
  // centre 5 -> pp10 p0 6 pm2 0p9 0m1 mp8 m0 4 mm0; centre 6 is each value + 1.
  function automatic window_t exp_win(input int k, input int base);
    int o;
    o = base + (k - 5);
    return '{pp: 8'(10 + o), p0: 8'(6 + o), pm: 8'(2 + o), zp: 8'(9 + o),
             zm: 8'(1 + o), mp: 8'(8 + o), m0: 8'(4 + o), mm: 8'(0 + o)};
  endfunction

  task automatic clear_capture();
    win_q.delete();
    xfer_cyc.delete();
    ready_low = 0;
  endtask

  task automatic send(input logic [7:0] pix, input logic sof);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_pixel = pix;
    in_sof   = sof;
    in_valid = 1'b1;
    @(posedge clock); #1;
    xfer_cyc.push_back(cyc);
    $display("pixel %0d sof=%b accepted cyc=%0d", pix, sof, cyc);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_frame(input int base, input int gap_after, input int gap_len);
    for (int i = 0; i < W * H; i++) begin
      send(8'(base + i), i == 0);
      if (i == gap_after) begin
        repeat (gap_len) begin
          @(posedge clock); #1;
        end
      end
    end
    repeat (10) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    checks++;
    if ({on_edge, out_eof} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b required 00", {on_edge, out_eof}); end
    checks++;
    if ({pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm} !== 64'h0) begin
      errors++;
      $display("FAIL reset_pixels: got %h required 0",
               {pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_0m, pixel_mp, pixel_m0, pixel_mm});
    end
    rst = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic_frame();
    int interior;
    int eofs;
    clear_capture();
    run_frame(0, -1, 0);
    checks++;
    if (win_q.size() != 12) begin errors++; $display("FAIL basic_count: got %0d required 12", win_q.size()); end
    if (win_q.size() == 12) begin
      checks++;
      if (win_q[0].cyc != xfer_cyc[5]) begin
        errors++; $display("FAIL basic_first_latency: got cyc %0d required %0d", win_q[0].cyc, xfer_cyc[5]);
      end
      interior = 0;
      eofs = 0;
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (win_q[k].e !== ((k == 5 || k == 6) ? 1'b0 : 1'b1)) begin
          errors++; $display("FAIL basic_edge[%0d]: got %b required %b", k, win_q[k].e, !(k == 5 || k == 6));
        end
        checks++;
        if (win_q[k].f !== ((k == 11) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL basic_eof[%0d]: got %b required %b", k, win_q[k].f, k == 11);
        end
        checks++;
        if (win_q[k].cyc != ((k < 7) ? xfer_cyc[k + 5] : xfer_cyc[11] + (k - 6))) begin
          errors++; $display("FAIL basic_timing[%0d]: got cyc %0d", k, win_q[k].cyc);
        end
        if (k >= 7) begin
          checks++;
          if (win_q[k].w !== '0) begin errors++; $display("FAIL basic_flush_zero[%0d]: got %h required 0", k, win_q[k].w); end
        end
        if (win_q[k].e === 1'b0) interior++;
        if (win_q[k].f === 1'b1) eofs++;
      end
      checks++;
      if (interior != 2) begin errors++; $display("FAIL basic_interior_count: got %0d required 2", interior); end
      checks++;
      if (eofs != 1) begin errors++; $display("FAIL basic_eof_count: got %0d required 1", eofs); end
      for (int k = 5; k <= 6; k++) begin
        checks++;
        if (win_q[k].w !== exp_win(k, 0)) begin
          errors++; $display("FAIL basic_window[%0d]: got %h required %h", k, win_q[k].w, exp_win(k, 0));
        end
      end
    end
    checks++;
    if (ready_low != 5) begin errors++; $display("FAIL basic_ready_low: got %0d required 5", ready_low); end
  endtask

  task automatic test_input_gaps();
    clear_capture();
    run_frame(0, 6, 3);
    checks++;
    if (win_q.size() != 12) begin errors++; $display("FAIL gap_count: got %0d required 12", win_q.size()); end
    if (win_q.size() == 12) begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (win_q[k].cyc != xfer_cyc[k + 5]) begin
          errors++; $display("FAIL gap_timing[%0d]: got cyc %0d required %0d", k, win_q[k].cyc, xfer_cyc[k + 5]);
        end
      end
      for (int k = 5; k <= 6; k++) begin
        checks++;
        if (win_q[k].w !== exp_win(k, 0)) begin
          errors++; $display("FAIL gap_window[%0d]: got %h required %h", k, win_q[k].w, exp_win(k, 0));
        end
      end
    end
  endtask

  task automatic test_sync();
    clear_capture();
    for (int i = 0; i < 3; i++) send(8'(200 + i), 1'b0);
    repeat (3) begin
      @(posedge clock); #1;
    end
    checks++;
    if (win_q.size() != 0) begin errors++; $display("FAIL sync_no_output: got %0d windows required 0", win_q.size()); end
    clear_capture();
    run_frame(20, -1, 0);
    checks++;
    if (win_q.size() != 12) begin errors++; $display("FAIL sync_count: got %0d required 12", win_q.size()); end
    if (win_q.size() == 12) begin
      for (int k = 5; k <= 6; k++) begin
        checks++;
        if (win_q[k].w !== exp_win(k, 20) || win_q[k].e !== 1'b0) begin
          errors++; $display("FAIL sync_window[%0d]: got %h edge %b required %h edge 0", k, win_q[k].w, win_q[k].e, exp_win(k, 20));
        end
      end
    end
  endtask

  task automatic test_abort();
    int eofs;
    clear_capture();
    for (int i = 0; i < 7; i++) send(8'(50 + i), i == 0);
    run_frame(100, -1, 0);
    checks++;
    if (win_q.size() != 14) begin errors++; $display("FAIL abort_count: got %0d required 14", win_q.size()); end
    eofs = 0;
    foreach (win_q[k]) if (win_q[k].f === 1'b1) eofs++;
    checks++;
    if (eofs != 1) begin errors++; $display("FAIL abort_eof_count: got %0d required 1", eofs); end
    if (win_q.size() == 14) begin
      checks++;
      if (win_q[13].f !== 1'b1) begin errors++; $display("FAIL abort_eof_last: got %b required 1", win_q[13].f); end
      for (int k = 5; k <= 6; k++) begin
        checks++;
        if (win_q[k + 2].w !== exp_win(k, 100) || win_q[k + 2].e !== 1'b0) begin
          errors++; $display("FAIL abort_window[%0d]: got %h edge %b required %h edge 0", k, win_q[k + 2].w, win_q[k + 2].e, exp_win(k, 100));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int eofs;
    clear_capture();
    for (int i = 0; i < 8; i++) send(8'(i), i == 0);
    rst = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", in_ready); end
    rst = 1'b0;
    @(posedge clock); #1;
    clear_capture();
    run_frame(0, -1, 0);
    checks++;
    if (win_q.size() != 12) begin errors++; $display("FAIL midrst_count: got %0d required 12", win_q.size()); end
    eofs = 0;
    foreach (win_q[k]) if (win_q[k].f === 1'b1) eofs++;
    checks++;
    if (eofs != 1) begin errors++; $display("FAIL midrst_eof_count: got %0d required 1", eofs); end
    if (win_q.size() == 12) begin
      for (int k = 5; k <= 6; k++) begin
        checks++;
        if (win_q[k].w !== exp_win(k, 0)) begin
          errors++; $display("FAIL midrst_window[%0d]: got %h required %h", k, win_q[k].w, exp_win(k, 0));
        end
      end
    end
    checks++;
    if (ready_low != 5) begin errors++; $display("FAIL midrst_ready_low: got %0d required 5", ready_low); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_input_gaps();
    test_sync();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
